// File: rtl/rv32i_arb_pkg.sv
// Shared types for the RV32I memory-port arbiter: FSM state encoding and requester ids.
package rv32i_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_LSU    = 1'b1;

endpackage

// File: rtl/two_to_1_mux.sv
// Plain 2:1 multiplexer: sel=0 passes input_1, sel=1 passes input_2.
module two_to_1_mux #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] input_1,
  input  logic [DWIDTH-1:0] input_2,
  input  logic              sel,
  output logic [DWIDTH-1:0] mux_out
);

  assign mux_out = sel ? input_2 : input_1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single RV32I memory port shared by instruction fetch (0)
// and the load/store unit (1), with completion pulses, read-data return and timeout.
module mem_port_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DWIDTH-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              sel
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic                r_last_gnt;
  logic                r_sel;
  logic [CW-1:0]       r_cnt;
  logic                r_done0;
  logic                r_done1;
  logic                r_err;
  logic [DWIDTH-1:0]   r_rdata;

  logic w_elig0;
  logic w_elig1;
  logic w_owner;
  logic w_granted;
  logic w_ack;
  logic w_timeout;
  logic w_release;

  // A requester whose done pulse is showing may still hold req; it must not win again.
  assign w_elig0   = req0 && !r_done0;
  assign w_elig1   = req1 && !r_done1;
  assign w_owner   = (r_state == GRANT1);
  assign w_granted = (r_state != IDLE);
  assign w_ack     = w_granted && mem_ack;
  assign w_timeout = w_granted && !mem_ack && (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_release = w_ack || w_timeout;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_elig0 && w_elig1) begin
          w_next_state = (r_last_gnt == REQ_LSU) ? GRANT0 : GRANT1;
        end else if (w_elig0) begin
          w_next_state = GRANT0;
        end else if (w_elig1) begin
          w_next_state = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (w_release) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    mem_we  = 1'b0;
    unique case (r_state)
      GRANT0: begin
        gnt0   = 1'b1;
        mem_we = we0;
      end
      GRANT1: begin
        gnt1   = 1'b1;
        mem_we = we1;
      end
      default: ;
    endcase
    mem_req = gnt0 || gnt1;
  end

  // Completion bookkeeping; the counter sits at zero while idle so each grant starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= REQ_LSU;
      r_sel      <= REQ_IFETCH;
      r_cnt      <= '0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      if (!w_granted) begin
        r_cnt <= '0;
        if (w_next_state == GRANT0) begin
          r_sel <= REQ_IFETCH;
        end else if (w_next_state == GRANT1) begin
          r_sel <= REQ_LSU;
        end
      end else if (w_release) begin
        r_done0    <= !w_owner;
        r_done1    <= w_owner;
        r_err      <= w_timeout;
        r_last_gnt <= w_owner;
        if (w_ack && !mem_we) r_rdata <= mem_rdata;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign done0 = r_done0;
  assign done1 = r_done1;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign sel   = r_sel;

  two_to_1_mux #(.DWIDTH(AWIDTH)) u_addr_mux (
    .input_1 (addr0),
    .input_2 (addr1),
    .sel     (r_sel),
    .mux_out (mem_addr)
  );

  two_to_1_mux #(.DWIDTH(DWIDTH)) u_wdata_mux (
    .input_1 (wdata0),
    .input_2 (wdata1),
    .sel     (r_sel),
    .mux_out (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level ownership model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1, mem_ack;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, mem_rdata;
  logic          gnt0, gnt1, done0, done1, err, mem_req, mem_we, sel;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we0       (we0),
    .we1       (we1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .sel       (sel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Ownership model: who holds the port, how long it has waited, who finished last.
  int            m_owner;
  int            m_age;
  int            m_last;
  bit            m_new;
  bit            m_sel;
  bit            m_err;
  bit [1:0]      m_done;
  logic [DW-1:0] m_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = 1;
    m_new   = 1'b0;
    m_sel   = 1'b0;
    m_err   = 1'b0;
    m_done  = 2'b00;
    m_rdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_step();
    bit [1:0]      r;
    bit [1:0]      w;
    bit [1:0]      nd;
    bit            ne;
    logic [DW-1:0] nr;
    r  = {req1, req0};
    w  = {we1, we0};
    nd = 2'b00;
    ne = 1'b0;
    nr = '0;
    m_new = 1'b0;
    if (m_owner >= 0) begin
      if (mem_ack) begin
        nd[m_owner] = 1'b1;
        nr          = w[m_owner] ? '0 : mem_rdata;
        m_last      = m_owner;
        m_owner     = -1;
      end else if (TO != 0 && m_age == TO - 1) begin
        nd[m_owner] = 1'b1;
        ne          = 1'b1;
        m_last      = m_owner;
        m_owner     = -1;
      end else begin
        m_age++;
      end
    end else begin
      bit e0, e1;
      e0 = r[0] && !m_done[0];
      e1 = r[1] && !m_done[1];
      if (e0 && e1)  m_owner = 1 - m_last;
      else if (e0)   m_owner = 0;
      else if (e1)   m_owner = 1;
      if (m_owner >= 0) begin
        m_age = 0;
        m_sel = (m_owner == 1);
        m_new = 1'b1;
      end
    end
    m_done  = nd;
    m_err   = ne;
    m_rdata = nr;
  endtask

  task automatic compare();
    check("gnt0", gnt0, m_owner == 0);
    check("gnt1", gnt1, m_owner == 1);
    check("mem_req", mem_req, m_owner >= 0);
    check("done0", done0, m_done[0]);
    check("done1", done1, m_done[1]);
    check("err", err, m_err);
    check("rdata", rdata, m_rdata);
    check("sel", sel, m_sel);
    check("gnt_both", gnt0 & gnt1, 1'b0);
    check("done_both", done0 & done1, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  // Combinational mux path, checked after the bench has settled new inputs.
  task automatic check_mux();
    #1;
    if (m_owner == 0) begin
      check("mem_addr0", mem_addr, addr0);
      check("mem_wdata0", mem_wdata, wdata0);
      check("mem_we0", mem_we, we0);
    end else if (m_owner == 1) begin
      check("mem_addr1", mem_addr, addr1);
      check("mem_wdata1", mem_wdata, wdata1);
      check("mem_we1", mem_we, we1);
    end else begin
      check("mem_we_idle", mem_we, 1'b0);
    end
  endtask

  task automatic drive_req(input int x, input bit v);
    if (x == 0) begin
      req0 = v;
      if (v) begin addr0 = $urandom; wdata0 = $urandom; we0 = 1'($urandom % 2); end
    end else begin
      req1 = v;
      if (v) begin addr1 = $urandom; wdata1 = $urandom; we1 = 1'($urandom % 2); end
    end
  endtask

  task automatic quiet(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_ack = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_gnt", {gnt1, gnt0}, 2'b00);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_done", {done1, done0, err}, 3'b000);
    check("rst_rdata", rdata, '0);
    check("rst_sel", sel, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int  order[$];
  bit  pg0, pg1, seen;
  int  cnt, ack_lat;
  bit  abandoned [2];
  bit  cur;

  initial begin
    do_reset();

    // 1: single fetch read, ack two cycles after the grant
    req0 = 1'b1; addr0 = 32'h0000_0100; we0 = 1'b0; wdata0 = 32'h5555_aaaa;
    tick();
    check_mux();
    check("t1_gnt0", gnt0, 1'b1);
    check("t1_addr", mem_addr, 32'h0000_0100);
    check("t1_sel", sel, 1'b0);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hdead_beaf;
    tick();
    check("t1_done0", done0, 1'b1);
    check("t1_rdata", rdata, 32'hdead_beaf);
    check("t1_gnt0_low", gnt0, 1'b0);
    quiet(2);

    // 2: simultaneous requests after reset alternate 0,1,0,1
    do_reset();
    drive_req(0, 1); drive_req(1, 1);
    pg0 = 1'b0; pg1 = 1'b0;
    order.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt0 && !pg0) order.push_back(0);
      if (gnt1 && !pg1) order.push_back(1);
      pg0 = gnt0; pg1 = gnt1;
      mem_ack = (m_owner >= 0);
      check_mux();
    end
    check("t2_ngrants", order.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < order.size(); i++) check($sformatf("t2_order%0d", i), order[i], i % 2);
    quiet(2);

    // 3: LSU write with immediate ack
    req1 = 1'b1; addr1 = 32'h0000_2000; wdata1 = 32'h1234_5678; we1 = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hcafe_f00d;
    check_mux();
    check("t3_we", mem_we, 1'b1);
    check("t3_wdata", mem_wdata, 32'h1234_5678);
    check("t3_sel", sel, 1'b1);
    tick();
    check("t3_done1", done1, 1'b1);
    check("t3_rdata0", rdata, '0);
    quiet(2);

    // 4: no ack -> 16 grant cycles then done0+err
    drive_req(0, 1);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (mem_req) cnt++;
      if (done0) begin
        seen = 1'b1;
        check("t4_err", err, 1'b1);
        check("t4_len", cnt, TO);
        req0 = 1'b0;
      end
    end
    check("t4_done_seen", seen, 1'b1);
    tick();
    check("t4_err_pulse", err, 1'b0);
    drive_req(1, 1); we1 = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0bad_c0de;
    tick();
    check("t4_next_done", done1, 1'b1);
    check("t4_next_err", err, 1'b0);
    check("t4_next_rdata", rdata, 32'h0bad_c0de);
    quiet(2);

    // 5: ack on the last allowed cycle wins over the timeout
    drive_req(0, 1);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    check("t5_still_granted", mem_req, 1'b1);
    mem_ack = 1'b1;
    tick();
    check("t5_done0", done0, 1'b1);
    check("t5_err", err, 1'b0);
    quiet(2);

    // random traffic against the model
    abandoned[0] = 1'b0; abandoned[1] = 1'b0;
    ack_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        cur = (x == 0) ? req0 : req1;
        if (m_done[x]) begin
          drive_req(x, 1'($urandom % 2));
          abandoned[x] = 1'b0;
        end else if (!cur) begin
          if (abandoned[x] && m_owner != x) abandoned[x] = 1'b0;
          if (!abandoned[x] && $urandom % 4 == 0) drive_req(x, 1'b1);
        end else if (m_owner == x && $urandom % 32 == 0) begin
          drive_req(x, 1'b0);
          abandoned[x] = 1'b1;
        end
      end
      if (m_new) begin
        case ($urandom % 8)
          0, 1, 2, 3, 4: ack_lat = int'($urandom % 4);
          5:             ack_lat = TO - 1;
          default:       ack_lat = 1000;
        endcase
      end
      if (m_owner >= 0) mem_ack = (m_age >= ack_lat);
      else              mem_ack = ($urandom % 8 == 0);
      mem_rdata = $urandom;
      check_mux();
    end
    quiet(3);

    // 6: async reset mid-grant, then first tie goes to requester 0
    drive_req(0, 1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("t6_granted", gnt0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt", {gnt1, gnt0}, 2'b00);
    check("t6_async_mem_req", mem_req, 1'b0);
    check("t6_async_done", {done1, done0}, 2'b00);
    req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_no_done", {done1, done0}, 2'b00);
    drive_req(0, 1); drive_req(1, 1);
    tick();
    check("t6_first_tie", gnt0, 1'b1);
    quiet(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
